inflight_tracker: RTL and testbench
===================================

INFLIGHT_TRACKER -- requirements
Module: inflight_tracker

Interface
REQ-001 Parameter: width, 64, data/address word width.
REQ-002 Parameter: SENTINEL, {width{1'b1}}, value driven on a check port whose slot is empty.
REQ-003 Parameter: TIMEOUT, 255, max cycles a slot may stay occupied (used only under INFLIGHT_TIMEOUT_EN).
REQ-004 Port: clk  input  1  clock; all state changes on posedge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: data_i  input  width  word accepted from the dependency-check stage.
REQ-007 Port: valid_i  input  1  data_i valid.
REQ-008 Port: ready_o  output  1  tracker can accept data_i this cycle.
REQ-009 Port: issue_data_o  output  width  word issued to the execution unit.
REQ-010 Port: issue_valid_o  output  1  issue_data_o valid.
REQ-011 Port: issue_ready_i  input  1  execution unit takes issue_data_o.
REQ-012 Port: done_data_i  input  width  word of a completed operation.
REQ-013 Port: done_valid_i  input  1  completion strobe, one cycle per completion.
REQ-014 Port: check_a_o, check_b_o, check_c_o  output  width each  contents of slots 0/1/2, or SENTINEL when empty; connect to the dependency checker.
REQ-015 Port: occupancy_o  output  2  number of occupied slots, 0..3.
REQ-016 Port: spurious_o  output  1  one-cycle pulse: completion matched no occupied slot.
REQ-017 Port: timeout_o  output  1  sticky watchdog error flag.

Function
REQ-018 Three slots, each holding a valid bit and a width-bit word; one-entry issue register.
REQ-019 ready_o = (at least one slot empty) AND (issue register empty OR issue_ready_i); combinational from registered state and issue_ready_i only.
REQ-020 Accept = valid_i & ready_o; on accept, the lowest-index empty slot (as of the start of the cycle) is loaded with data_i and marked occupied, and the issue register is loaded with data_i.
REQ-021 issue_valid_o rises the cycle after accept; issue register clears on issue_valid_o & issue_ready_i unless reloaded by a simultaneous accept (back-to-back issue, one word per cycle).
REQ-022 check_x_o and occupancy_o are registered; a newly accepted word appears on its check port the cycle after accept.
REQ-023 Completion: done_valid_i with done_data_i equal to an occupied slot's word frees that slot at the next edge; on multiple matches only the lowest-index match is freed.
REQ-024 Completion with no match: no state change; spurious_o pulses high the next cycle for one cycle.
REQ-025 Simultaneous accept and completion: slot freed this cycle is not reusable this cycle; occupancy_o reflects both (net unchanged when both occur).
REQ-026 Full (occupancy 3): ready_o = 0; a completion in that cycle makes ready_o = 1 the following cycle at the earliest.
REQ-027 A slot may be freed by completion before its word leaves the issue register; issue proceeds unaffected.
REQ-028 No combinational path from valid_i or data_i to any output.

Reset
REQ-029 On rst: all slots empty, issue register empty, issue_valid_o = 0, check_x_o = SENTINEL, occupancy_o = 0, spurious_o = 0, timeout_o = 0, issue_data_o = 0.
REQ-030 rst mid-operation discards all in-flight and pending words; inputs during rst are ignored; ready_o = 1 the first cycle after rst deasserts.

Configuration
REQ-031 Macro INFLIGHT_TIMEOUT_EN: when defined, each slot has an age counter cleared on allocation, incrementing each cycle while occupied, saturating at TIMEOUT; on reaching TIMEOUT, timeout_o sets and holds until rst.
REQ-032 Without INFLIGHT_TIMEOUT_EN: no age counters, timeout_o tied 0, all other behaviour identical.

Verification
REQ-033 Reset, then valid_i=1 with 0x10 -> next cycle check_a_o=0x10, check_b_o/check_c_o=SENTINEL, issue_valid_o=1, occupancy_o=1.
REQ-034 Accept 0x10, 0x20, 0x30 back-to-back with issue_ready_i=1 -> occupancy_o=3, ready_o=0; done 0x20 -> check_b_o=SENTINEL, ready_o=1 next cycle; next accept 0x40 lands in slot 1.
REQ-035 Full, same cycle done 0x10 and valid_i 0x50 -> 0x50 not accepted (ready_o=0); 0x50 accepted the following cycle into slot 0.
REQ-036 Occupancy 2 with issue_ready_i=1, done 0x10 and accept 0x60 same cycle -> occupancy_o stays 2, 0x60 in lowest slot empty at start of cycle.
REQ-037 done 0x99 matching no slot -> spurious_o high exactly one cycle, slots unchanged; issue_ready_i=0 with word pending -> ready_o=0, issue_data_o held.
REQ-038 INFLIGHT_TIMEOUT_EN, TIMEOUT=4: accept 0x10, no completion -> timeout_o=1 after 4 occupied cycles, stays 1 until rst; without macro timeout_o stays 0.

Source files
------------

// File: rtl/inflight_tracker_if.sv
// Handshake and status bundle between the dependency-check stage, the
// in-flight tracker and the execution unit.
// The tracker connects through the slave modport; the environment driving
// it connects through the master modport.
interface inflight_tracker_if #(
    parameter int width = 64
);
    // Accept side (from the dependency-check stage)
    logic [width-1:0] data_i;
    logic             valid_i;
    logic             ready_o;

    // Issue side (to the execution unit)
    logic [width-1:0] issue_data_o;
    logic             issue_valid_o;
    logic             issue_ready_i;

    // Completion side (from the execution unit)
    logic [width-1:0] done_data_i;
    logic             done_valid_i;

    // Slot visibility and status
    logic [width-1:0] check_a_o;
    logic [width-1:0] check_b_o;
    logic [width-1:0] check_c_o;
    logic [1:0]       occupancy_o;
    logic             spurious_o;
    logic             timeout_o;

    modport slave (
        input  data_i, valid_i, issue_ready_i, done_data_i, done_valid_i,
        output ready_o, issue_data_o, issue_valid_o,
               check_a_o, check_b_o, check_c_o,
               occupancy_o, spurious_o, timeout_o
    );

    modport master (
        output data_i, valid_i, issue_ready_i, done_data_i, done_valid_i,
        input  ready_o, issue_data_o, issue_valid_o,
               check_a_o, check_b_o, check_c_o,
               occupancy_o, spurious_o, timeout_o
    );
endinterface

// File: rtl/inflight_tracker.sv
// inflight_tracker: three-slot scoreboard of words currently in flight in the
// execution unit, with a one-entry issue register in front of the unit.
// A word is recorded in the lowest free slot when accepted and released when
// a matching completion arrives. Slot contents are exported on check_x_o for
// the dependency checker (SENTINEL marks an empty slot).
// Optional watchdog: define INFLIGHT_TIMEOUT_EN to add per-slot age counters
// that raise a sticky timeout_o once any slot has been occupied for TIMEOUT
// cycles. Without the macro timeout_o is held low.
module inflight_tracker #(
    parameter int               width    = 64,
    parameter logic [width-1:0] SENTINEL = {width{1'b1}},
    parameter int               TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    inflight_tracker_if.slave    bus
);

    // Slot state
    logic [2:0]            slot_valid_reg;
    logic [2:0]            slot_valid_next;
    logic [2:0][width-1:0] slot_word_reg;
    logic [2:0][width-1:0] slot_word_next;

    // Issue register
    logic                  issue_valid_reg;
    logic [width-1:0]      issue_data_reg;

    // Registered status outputs
    logic [2:0][width-1:0] check_reg;
    logic [1:0]            occupancy_reg;
    logic                  spurious_reg;

    // Per-cycle decisions
    logic [2:0] empty_vec;
    logic [2:0] alloc_onehot;
    logic [2:0] match_vec;
    logic [2:0] free_onehot;
    logic       any_empty;
    logic       ready;
    logic       accept;
    logic       any_match;

    // Allocation target is the lowest slot empty at the start of the cycle;
    // a slot being freed this cycle is still counted as occupied here.
    assign empty_vec    = ~slot_valid_reg;
    assign alloc_onehot = empty_vec & (~empty_vec + 3'd1);
    assign any_empty    = |empty_vec;

    // Ready depends only on registered state and issue_ready_i, never on
    // valid_i or data_i.
    assign ready  = any_empty & (~issue_valid_reg | bus.issue_ready_i);
    assign accept = bus.valid_i & ready;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
            assign match_vec[gi] = slot_valid_reg[gi] &&
                                   (slot_word_reg[gi] == bus.done_data_i);
        end
    endgenerate

    // Only the lowest matching slot is released on duplicate words.
    assign any_match   = |match_vec;
    assign free_onehot = bus.done_valid_i ? (match_vec & (~match_vec + 3'd1)) : 3'b000;

    // Next slot state: release the completed slot, then fill the allocated one.
    // The two never coincide because one is occupied and the other empty.
    always_comb begin
        slot_valid_next = (slot_valid_reg & ~free_onehot) |
                          (accept ? alloc_onehot : 3'b000);
        slot_word_next  = slot_word_reg;
        for (int i = 0; i < 3; i++) begin
            if (accept && alloc_onehot[i]) begin
                slot_word_next[i] = bus.data_i;
            end
        end
    end

    // Slot registers, occupancy count and completion status.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_reg <= 3'b000;
            slot_word_reg  <= '0;
            occupancy_reg  <= 2'd0;
            spurious_reg   <= 1'b0;
        end else begin
            slot_valid_reg <= slot_valid_next;
            slot_word_reg  <= slot_word_next;
            occupancy_reg  <= {1'b0, slot_valid_next[0]} +
                              {1'b0, slot_valid_next[1]} +
                              {1'b0, slot_valid_next[2]};
            spurious_reg   <= bus.done_valid_i & ~any_match;
        end
    end

    // Check ports are registered copies of the next slot state so that the
    // dependency checker sees a new word exactly one cycle after accept.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_check
            always_ff @(posedge clk) begin
                if (rst) begin
                    check_reg[gi] <= SENTINEL;
                end else begin
                    check_reg[gi] <= slot_valid_next[gi] ? slot_word_next[gi] : SENTINEL;
                end
            end
        end
    endgenerate

    // Issue register: loads on accept, drains when the execution unit takes
    // the word. A simultaneous accept refills it for back-to-back issue.
    // Completion of a slot has no effect on a word still waiting here.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_reg <= 1'b0;
            issue_data_reg  <= '0;
        end else if (accept) begin
            issue_valid_reg <= 1'b1;
            issue_data_reg  <= bus.data_i;
        end else if (bus.issue_ready_i) begin
            issue_valid_reg <= 1'b0;
        end
    end

`ifdef INFLIGHT_TIMEOUT_EN
    localparam int AGE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [2:0][AGE_W-1:0] age_reg;
    logic [2:0]            age_hit;
    logic                  timeout_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_age
            // A slot hits the limit on the edge where its age steps to TIMEOUT.
            assign age_hit[gi] = slot_valid_reg[gi] &&
                                 (age_reg[gi] == AGE_W'(TIMEOUT - 1));

            // Age restarts on allocation and saturates at TIMEOUT while occupied.
            always_ff @(posedge clk) begin
                if (rst) begin
                    age_reg[gi] <= '0;
                end else if (accept && alloc_onehot[gi]) begin
                    age_reg[gi] <= '0;
                end else if (slot_valid_reg[gi] && (age_reg[gi] != AGE_W'(TIMEOUT))) begin
                    age_reg[gi] <= age_reg[gi] + AGE_W'(1);
                end
            end
        end
    endgenerate

    // Sticky watchdog flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_reg <= 1'b0;
        end else if (|age_hit) begin
            timeout_reg <= 1'b1;
        end
    end

    assign bus.timeout_o = timeout_reg;
`else
    // Watchdog compiled out: flag is constant low for any legal TIMEOUT.
    assign bus.timeout_o = 1'b0 & (TIMEOUT < 0);
`endif

    assign bus.ready_o       = ready;
    assign bus.issue_valid_o = issue_valid_reg;
    assign bus.issue_data_o  = issue_data_reg;
    assign bus.check_a_o     = check_reg[0];
    assign bus.check_b_o     = check_reg[1];
    assign bus.check_c_o     = check_reg[2];
    assign bus.occupancy_o   = occupancy_reg;
    assign bus.spurious_o    = spurious_reg;

endmodule

// File: tb/tb_inflight_tracker.sv
// Testbench for inflight_tracker: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a slot/queue reference model.
module tb_inflight_tracker;
    localparam int             W    = 64;
    localparam int             TO   = 4;
    localparam logic [W-1:0]   SENT = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inflight_tracker_if #(.width(W)) bus();

    inflight_tracker #(
        .width    (W),
        .SENTINEL (SENT),
        .TIMEOUT  (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    bit           m_occ  [3];
    logic [W-1:0] m_word [3];
    int           m_age  [3];
    bit           m_pend;
    logic [W-1:0] m_pdata;
    bit           m_spur;
    bit           m_tout;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check ready_o mid-cycle, advance the
    // model at the edge and check all registered outputs after it.
    task automatic step(input bit r, input bit v, input logic [W-1:0] d,
                        input bit ir, input bit dv, input logic [W-1:0] dd);
        bit any_empty;
        bit exp_ready;
        bit acc;
        int match;
        int alloc;
        int occ_cnt;
        logic [W-1:0] exp_chk;

        rst               = r;
        bus.valid_i       = v;
        bus.data_i        = d;
        bus.issue_ready_i = ir;
        bus.done_valid_i  = dv;
        bus.done_data_i   = dd;

        @(negedge clk);
        any_empty = !m_occ[0] || !m_occ[1] || !m_occ[2];
        exp_ready = any_empty && (!m_pend || ir);
        if (!r) check_eq("ready", {63'd0, bus.ready_o}, {63'd0, exp_ready});

        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_occ[i] = 0; m_word[i] = '0; m_age[i] = 0;
            end
            m_pend = 0; m_pdata = '0; m_spur = 0; m_tout = 0;
        end else begin
            acc   = v && exp_ready;
            match = -1;
            alloc = -1;
            for (int i = 2; i >= 0; i--) begin
                if (dv && m_occ[i] && m_word[i] == dd) match = i;
                if (!m_occ[i]) alloc = i;
            end
            // Ages of slots occupied during this cycle
            for (int i = 0; i < 3; i++) begin
                if (m_occ[i]) begin
                    if (m_age[i] < TO) m_age[i]++;
                    if (m_age[i] == TO) m_tout = 1;
                end
            end
            m_spur = dv && (match < 0);
            if (match >= 0) m_occ[match] = 0;
            if (acc) begin
                m_occ[alloc]  = 1;
                m_word[alloc] = d;
                m_age[alloc]  = 0;
                m_pend  = 1;
                m_pdata = d;
            end else if (ir) begin
                m_pend = 0;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        occ_cnt = 0;
        for (int i = 0; i < 3; i++) if (m_occ[i]) occ_cnt++;
        exp_chk = m_occ[0] ? m_word[0] : SENT;
        check_eq("check_a", bus.check_a_o, exp_chk);
        exp_chk = m_occ[1] ? m_word[1] : SENT;
        check_eq("check_b", bus.check_b_o, exp_chk);
        exp_chk = m_occ[2] ? m_word[2] : SENT;
        check_eq("check_c", bus.check_c_o, exp_chk);
        check_eq("occupancy", {62'd0, bus.occupancy_o}, W'(occ_cnt));
        check_eq("issue_valid", {63'd0, bus.issue_valid_o}, {63'd0, m_pend});
        if (m_pend || r) check_eq("issue_data", bus.issue_data_o, m_pdata);
        check_eq("spurious", {63'd0, bus.spurious_o}, {63'd0, m_spur});
`ifdef INFLIGHT_TIMEOUT_EN
        check_eq("timeout", {63'd0, bus.timeout_o}, {63'd0, m_tout});
`else
        check_eq("timeout", {63'd0, bus.timeout_o}, 64'd0);
`endif
    endtask

    task automatic idle(input bit ir);
        step(0, 0, '0, ir, 0, '0);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] dd;
        int k;

        bus.valid_i = 0; bus.data_i = '0; bus.issue_ready_i = 0;
        bus.done_valid_i = 0; bus.done_data_i = '0;

        // Reset state, then single accept
        step(1, 0, '0, 0, 0, '0);
        step(1, 1, 64'h77, 1, 1, 64'h77);
        step(0, 1, 64'h10, 1, 0, '0);
        idle(1);

        // Fill, complete middle slot, refill into slot 1
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 64'h10, 1, 0, '0);
        step(0, 1, 64'h20, 1, 0, '0);
        step(0, 1, 64'h30, 1, 0, '0);
        step(0, 1, 64'h44, 1, 0, '0);
        step(0, 0, '0, 1, 1, 64'h20);
        step(0, 1, 64'h40, 1, 0, '0);

        // Full: completion and offered word in the same cycle
        step(0, 1, 64'h50, 1, 1, 64'h10);
        step(0, 1, 64'h50, 1, 0, '0);

        // Occupancy 2: completion and accept together
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 64'h10, 1, 0, '0);
        step(0, 1, 64'h20, 1, 0, '0);
        step(0, 1, 64'h60, 1, 1, 64'h10);

        // Spurious completion, then issue stall
        step(0, 0, '0, 1, 1, 64'h99);
        idle(1);
        step(0, 1, 64'h70, 0, 0, '0);
        step(0, 1, 64'h80, 0, 0, '0);
        step(0, 1, 64'h80, 0, 1, 64'h20);
        step(0, 1, 64'h80, 1, 0, '0);

        // Long-lived slot for the watchdog, then reset mid-operation
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 64'h10, 1, 0, '0);
        for (int i = 0; i < 7; i++) idle(1);
        step(1, 1, 64'h33, 1, 0, '0);
        step(0, 1, 64'h33, 1, 0, '0);

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            d  = W'(64'h10 * (1 + $urandom_range(0, 7)));
            dd = W'(64'h10 * (1 + $urandom_range(0, 7)));
            k  = $urandom_range(0, 2);
            if ($urandom_range(0, 3) != 0 && m_occ[k]) dd = m_word[k];
            if ($urandom_range(0, 15) == 0) dd = 64'h99;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0), d,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), dd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
